// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined subtractor: diff = a - b - bin computed as a + ~b + ~bin with
// 4-bit carry-lookahead groups; low half in stage 1, high half and flags in stage 2.

module cla_sub_pipe_cla #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    localparam int unsigned NG = (N + 3) / 4;
    localparam int unsigned PW = NG * 4;

    logic [PW-1:0] p;
    logic [PW-1:0] g;
    logic [PW:0]   cv;
    logic [NG:0]   gc;

    // Carries into each bit of a 4-bit group, flattened to sum-of-products (no ripple).
    function automatic logic [3:0] grp_carry(input logic [3:0] gp, input logic [3:0] gg,
                                             input logic c0);
        logic [3:0] c;
        logic       t;
        c = 4'b0;
        for (int j = 0; j < 4; j++) begin
            t = c0;
            for (int i = 0; i < j; i++) t = t & gp[i];
            c[j] = t;
            for (int k = 0; k < j; k++) begin
                t = gg[k];
                for (int i = k + 1; i < j; i++) t = t & gp[i];
                c[j] = c[j] | t;
            end
        end
        return c;
    endfunction

    always_comb begin
        p  = '0;
        g  = '0;
        cv = '0;
        gc = '0;
        p[N-1:0] = x ^ y;
        g[N-1:0] = x & y;
        gc[0]    = cin;
        for (int k = 0; k < int'(NG); k++) begin
            cv[4*k +: 4] = grp_carry(p[4*k +: 4], g[4*k +: 4], gc[k]);
            gc[k+1] = g[4*k+3]
                    | (p[4*k+3] & g[4*k+2])
                    | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                    | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                    | ((&p[4*k +: 4]) & gc[k]);
        end
        cv[PW] = gc[NG];
    end

    assign s    = p[N-1:0] ^ cv[N-1:0];
    assign cout = cv[N];
endmodule

module cla_sub_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned H = WIDTH / 2;

    logic         s1_valid;
    logic         s2_valid;
    logic         s2_take;
    logic         s1_adv;
    logic         accept;

    logic [H-1:0] lo_sum;
    logic         c_h;
    logic [H-1:0] s1_lo_diff;
    logic         s1_c_h;
    logic [H-1:0] s1_a_hi;
    logic [H-1:0] s1_nb_hi;
    logic         s1_a_msb;

    logic [H-1:0]     hi_sum;
    logic             c_w;
    logic [WIDTH-1:0] diff_next;
    logic             ovf_next;

    // Handshake: out_ready reaches in_ready combinationally so a full pipe still streams.
    assign s2_take  = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_take;
    assign in_ready = !s1_valid || s2_take;
    assign accept   = in_valid && in_ready;

    cla_sub_pipe_cla #(.N(H)) u_lo (
        .x    (a[H-1:0]),
        .y    (~b[H-1:0]),
        .cin  (~bin),
        .s    (lo_sum),
        .cout (c_h)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_lo_diff <= '0;
            s1_c_h     <= 1'b0;
            s1_a_hi    <= '0;
            s1_nb_hi   <= '0;
            s1_a_msb   <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_lo_diff <= lo_sum;
            s1_c_h     <= c_h;
            s1_a_hi    <= a[WIDTH-1:H];
            s1_nb_hi   <= ~b[WIDTH-1:H];
            s1_a_msb   <= a[WIDTH-1];
        end else if (s1_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    cla_sub_pipe_cla #(.N(H)) u_hi (
        .x    (s1_a_hi),
        .y    (s1_nb_hi),
        .cin  (s1_c_h),
        .s    (hi_sum),
        .cout (c_w)
    );

    // Signed overflow only when operand signs differ and the result sign leaves a's sign.
    assign diff_next = {hi_sum, s1_lo_diff};
    assign ovf_next  = (s1_a_msb != ~s1_nb_hi[H-1]) && (hi_sum[H-1] != s1_a_msb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            diff     <= diff_next;
            bout     <= ~c_w;
            ovf      <= ovf_next;
            zero     <= (diff_next == '0);
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;
endmodule

// File: tb/tb_cla_sub_pipe.sv
// Scoreboard bench for cla_sub_pipe: accepted operands push an arithmetic-model
// expectation; a negedge monitor pops and compares each delivered result.

module tb_cla_sub_pipe;
    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   lat_chk = 0;
    bit   rnd_or = 0;
    logic or_val = 0;

    cla_sub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rnd_or ? ($urandom_range(0, 2) != 0) : or_val;
        end
    end

    // Reference: plain integer arithmetic, unsigned for borrow, signed range for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bi);
        exp_t e;
        int ur;
        int sr;
        ur = int'(x) - int'(y) - int'(bi);
        sr = int'($signed(x)) - int'($signed(y)) - int'(bi);
        e.diff = W'(ur);
        e.bout = (ur < 0);
        e.ovf  = (sr > 32767) || (sr < -32768);
        e.zero = (W'(ur) == '0);
        e.cyc  = cyc;
        e.lat  = lat_chk;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: scoreboard pop/compare, latency, and stall stability.
    initial begin : monitor
        exp_t         e;
        bit           prev_stall;
        logic [W+2:0] snap;
        prev_stall = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall)
                    check("stall_hold", 32'({out_valid, diff, bout, ovf, zero}),
                          32'({1'b1, snap}));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_out", 32'(out_valid), 32'(0));
                    end else begin
                        e = q.pop_front();
                        checks = checks + 1;
                        if ({diff, bout, ovf, zero} !== {e.diff, e.bout, e.ovf, e.zero}) begin
                            errors = errors + 1;
                            $display("FAIL result: got diff=%h bout=%b ovf=%b zero=%b want diff=%h bout=%b ovf=%b zero=%b",
                                     diff, bout, ovf, zero, e.diff, e.bout, e.ovf, e.zero);
                        end
                        if (e.lat) check("latency", 32'(cyc - e.cyc), 32'(2));
                    end
                end
                if (in_valid && in_ready) q.push_back(model(a, b, bin));
                prev_stall = out_valid && !out_ready;
                snap = {diff, bout, ovf, zero};
            end
        end
    end

    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin);
        int t;
        t = 0;
        a = xa;
        b = xb;
        bin = xbin;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                check("accept_timeout", 32'(in_ready), 32'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic v);
        or_val = v;
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [W-1:0] da[8];
    logic [W-1:0] db[8];
    logic         dbin[8];

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        da   = '{16'h1234, 16'h0000, 16'h0100, 16'h8000, 16'h5A5A, 16'h7FFF, 16'hFFFF, 16'h0000};
        db   = '{16'h0234, 16'h0001, 16'h0000, 16'h0001, 16'h5A5A, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        dbin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        #3;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_outputs", 32'({diff, bout, ovf, zero}), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // Directed vectors with free-flowing output.
        settle(1'b1);
        lat_chk = 1;
        for (int i = 0; i < 8; i++) send(da[i], db[i], dbin[i]);
        drain();
        lat_chk = 0;

        // Asynchronous reset with two operations in flight.
        settle(1'b0);
        send(16'h1111, 16'h0001, 1'b0);
        send(16'h2222, 16'h0002, 1'b0);
        check("full_before_rst", 32'({out_valid, in_ready}), 32'(2'b10));
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_outputs", 32'({diff, bout, ovf, zero}), 32'(0));
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;

        // Backpressure: five ops against a stalled consumer.
        settle(1'b0);
        fork
            begin
                for (int i = 0; i < 5; i++) send(W'($urandom), W'($urandom), 1'($urandom));
            end
            begin
                int base;
                base = q.size();
                repeat (4) @(negedge clk);
                check("bp_accepts", 32'(q.size() - base), 32'(2));
                check("bp_in_ready", 32'(in_ready), 32'(0));
                or_val = 1'b1;
            end
        join
        drain();

        // Full-rate stream.
        settle(1'b1);
        lat_chk = 1;
        for (int i = 0; i < 64; i++) send(W'($urandom), W'($urandom), 1'($urandom));
        drain();
        lat_chk = 0;

        // Random valid/ready.
        rnd_or = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(W'($urandom), W'($urandom), 1'($urandom));
        end
        rnd_or = 0;
        or_val = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cla_sub_pipe.md
Name: cla_sub_pipe

Overview:
- Two-stage pipelined subtractor computing a − b − bin over WIDTH bits, with a valid/ready handshake on both sides.
- Built on the team's carry-lookahead style, in the inverse direction of the CLA adder: a + ~b + ~bin.
  - Stage 1 resolves the low half and its borrow.
  - Stage 2 resolves the high half and the flags.
- Sits between an operand source and a result consumer in the arithmetic datapath. Throughput is one operation per cycle.

Parameters:
- WIDTH, 16, operand width. Must be even and ≥ 4. The split point is H = WIDTH/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend (unsigned or two's complement)
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH
- bout  output  1  unsigned borrow-out
- ovf  output  1  signed overflow
- zero  output  1  diff == 0

Behaviour:

Reset:
- rst high clears s1_valid and s2_valid immediately, without waiting for clk.
- All outputs are 0 during and after reset: diff, bout, ovf, zero and out_valid.
- in_ready = 1 once rst deasserts.
- Any in-flight operations are discarded, including on reset asserted mid-pipeline.

Arithmetic:
- Computed as a + ~b + cin, with cin = ~bin.
- bout = ~carry_out(WIDTH), equivalently bout = 1 iff a < b + bin (unsigned).
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- zero = (diff == 0).
- The low half is computed with 4-bit lookahead groups (group P/G). Ripple inside a group is not allowed.

Stage 1 register, loaded on input handshake (in_valid && in_ready):
- lo_diff[H−1:0] and the intermediate carry c_H.
- a_hi, b_hi (already inverted) and a[MSB].
- s1_valid.

Stage 2 register, loaded when stage 1 advances:
- diff = {hi_diff, lo_diff}, where the high half uses c_H as its carry-in.
- bout, ovf, zero.
- s2_valid. out_valid = s2_valid.

Flow control:
- s2_take = !s2_valid || out_ready.
- s1_adv = s1_valid && s2_take.
- in_ready = !s1_valid || s2_take. This is a combinational path from out_ready.
- On an output handshake with no stage-1 advance, s2_valid clears.
- If stage 1 is not refilled in the same cycle it advances, s1_valid clears.

Latency and ordering:
- Latency is exactly 2 cycles: an input accepted at edge N gives out_valid after edge N+1, provided out_ready stayed high.
- Results leave in acceptance order. No drops or duplicates.

Stall:
- While out_valid && !out_ready, diff/bout/ovf/zero/out_valid hold stable.
- The block holds at most 2 items. When both stages are full and stalled, in_ready = 0.

Simultaneous events:
- With the pipeline full and out_ready = 1, output, shift and input all occur in the same cycle. Sustained throughput is 1 per cycle.

Idle outputs:
- When out_valid = 0, the data outputs keep their last value (0 after reset) and must be ignored.

Inputs while not ready:
- a, b and bin are ignored when in_valid && !in_ready.

Test Plan:
1. Reset mid-flight: load two ops, assert rst asynchronously between edges → out_valid drops to 0 immediately, all outputs 0, in_ready = 1 after release.
2. Basic (WIDTH=16), out_ready = 1:
   - a=0x1234, b=0x0234, bin=0 → diff=0x1000, bout=0, ovf=0, zero=0, exactly 2 cycles after accept.
   - a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0.
3. Cross-half borrow and flags:
   - a=0x0100, b=0x0000, bin=1 → diff=0x00FF, bout=0.
   - a=0x8000, b=0x0001 → diff=0x7FFF, ovf=1.
   - a=0x5A5A, b=0x5A5A → zero=1.
   - a=0x7FFF, b=0xFFFF → diff=0x8000, bout=1, ovf=1.
4. Backpressure: stream 5 ops with out_ready=0 for 4 cycles → in_ready falls after 2 accepts, outputs stay stable; on release the 5 results appear in order, one per cycle, none lost.
5. Full-rate stream: 64 random ops, in_valid = out_ready = 1 continuously → 64 results, 1 per cycle, each matching the reference a − b − bin and its flags.
6. Random stalls: random in_valid/out_ready, 10k ops against a scoreboard model → exact match, in order, and outputs never change while stalled.
